ifetch_ctrl: RTL
================

# ifetch_ctrl

Instruction-fetch controller that owns the program counter and drives the instruction bus, producing the `raw_instr` / `pc` pair consumed by the fetch/decode stage. It issues one bus request at a time, holds the returned instruction until the downstream pipeline accepts it, and handles control-flow redirects, including redirects that arrive while a bus request is still outstanding. It sits between the core's instruction-bus port and the fetch stage.

## Interface

Parameters:
- `PCINIT`, default 64'h8000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireq_valid`  out  1  instruction-bus request valid.
- `ireq_addr`  out  64  request address; always equals the internal fetch PC (`fpc`).
- `iresp_data_ok`  in  1  one-cycle pulse: response data valid this cycle.
- `iresp_data`  in  32  instruction word; sampled only when `iresp_data_ok` is 1.
- `instr_valid`  out  1  `raw_instr`/`pc` hold a valid instruction for the fetch stage.
- `raw_instr`  out  32  held instruction word.
- `pc`  out  64  address of the held instruction.
- `stall`  in  1  downstream cannot accept this cycle.
- `redirect_valid`  in  1  control-flow change; takes priority over `stall`.
- `redirect_pc`  in  64  redirect target, sampled when `redirect_valid` is 1.

## Operation

The controller is a four-state FSM. Its registers are `state`, `fpc` (fetch PC), `hold_instr`, `hold_pc` and `pend_pc`.

- **IDLE**
  - Entered only from reset.
  - Next cycle goes to REQ unconditionally.
  - A redirect in this state loads `fpc` with `redirect_pc`.
- **REQ**
  - `ireq_valid`=1, `ireq_addr`=`fpc`; both are held stable until `iresp_data_ok`.
  - On `iresp_data_ok` without a redirect: capture `hold_instr`←`iresp_data` and `hold_pc`←`fpc`, then go to HOLD.
  - On `redirect_valid`: `pend_pc`←`redirect_pc`.
    - If `iresp_data_ok` arrives the same cycle, discard the data, load `fpc`←`redirect_pc`, and stay in REQ (a new request goes out next cycle).
    - Otherwise go to DROP.
  - The address is never changed while a request is outstanding.
- **DROP**
  - `ireq_valid` stays 1 and `ireq_addr` stays the old `fpc`.
  - A further redirect overwrites `pend_pc`; the last redirect wins.
  - On `iresp_data_ok`: discard the data, load `fpc`←`pend_pc` (or `redirect_pc` if a redirect arrives the same cycle), and go to REQ.
- **HOLD**
  - `instr_valid`=1, `raw_instr`=`hold_instr`, `pc`=`hold_pc`; `ireq_valid`=0.
  - On `redirect_valid`: the held instruction is squashed, `fpc`←`redirect_pc`, go to REQ.
  - Else if `stall`=0: the instruction is consumed this cycle, `fpc`←`hold_pc`+4 (64-bit modulo 2^64), go to REQ.
  - Else: remain in HOLD with all outputs stable.

General rules:
- `instr_valid` is 1 only in HOLD; `raw_instr` and `pc` are don't-care otherwise.
- `iresp_data_ok` received in IDLE or HOLD is a protocol error and is ignored.
- No alignment check is made; PC bits [1:0] pass through unchanged.

## Timing

- **Reset (async, `resetn`=0):**
  - Registers: `state`=IDLE, `fpc`=`PCINIT`, `hold_instr`=0, `hold_pc`=0, `pend_pc`=0.
  - Outputs: `ireq_valid`=0, `instr_valid`=0, `raw_instr`=0, `pc`=0, `ireq_addr`=`PCINIT`.
- **First request:** `ireq_valid` rises in the second rising edge's cycle after `resetn` deasserts (IDLE for one cycle, then REQ).
- **Fetch latency:** `instr_valid` rises the cycle after `iresp_data_ok`; all outputs are registered (Moore-style).
- **Back-to-back fetch:** the consume cycle in HOLD is followed by a REQ cycle with the new address. With a zero-wait bus (`data_ok` in the first REQ cycle), throughput is one instruction per 2 cycles.
- **Reset mid-request:** the FSM returns to IDLE immediately. Any late `iresp_data_ok` arriving in IDLE is ignored, and the first post-reset request is to `PCINIT`.
- **Simultaneous `redirect_valid` and `stall` in HOLD:** the redirect is taken.
- **`fpc` wrap:** 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Test plan

- **Reset and first fetch:** release reset, bus answers `data_ok` 2 cycles after `ireq_valid` with 32'h0000_0013 → `ireq_addr`=64'h8000_0000; `instr_valid`=1 with `pc`=64'h8000_0000 and `raw_instr`=32'h0000_0013 one cycle after `data_ok`.
- **Stall hold:** hold `stall`=1 for 5 cycles in HOLD → outputs stable and `ireq_valid`=0 throughout. Release `stall` → next request address is 64'h8000_0004.
- **Redirect while outstanding:** redirect to 64'h8000_0100 in cycle 1 of REQ, `data_ok` 3 cycles later with 32'hDEAD_BEEF → the DEAD_BEEF word is never presented (`instr_valid` stays 0); the next request is to 64'h8000_0100.
- **Double redirect in DROP:** redirects to 64'h200 then 64'h300 before `data_ok` → next request is to 64'h300.
- **Redirect in HOLD with stall=1:** redirect to 64'h8000_0040 → held instruction squashed, `instr_valid`=0 the next cycle, and a request to 64'h8000_0040 is issued.
- **Async reset mid-REQ:** assert `resetn`=0 for 1 cycle while `ireq_valid`=1 → `ireq_valid` drops without waiting for a clock edge; the first post-reset request is to `PCINIT`, and a stale `data_ok` during IDLE is ignored.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Instruction-fetch bundle: bus request/response plus the raw_instr/pc hand-off to the fetch stage.
// Latency: none, signal bundle only.
// Backpressure: stall from the fetch stage, redirect_valid overrides it; the bus answers with data_ok pulses.
// Ports (master = fetch controller, slave = instruction bus + downstream pipeline):
//   ireq_valid/ireq_addr       request to the instruction bus
//   iresp_data_ok/iresp_data   one-cycle response pulse and instruction word
//   instr_valid/raw_instr/pc   held instruction presented to the fetch stage
//   stall                      downstream cannot accept this cycle
//   redirect_valid/redirect_pc control-flow change and its target
interface ifetch_ctrl_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        instr_valid;
   logic [31:0] raw_instr;
   logic [63:0] pc;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   modport master (
      output ireq_valid, ireq_addr, instr_valid, raw_instr, pc,
      input  iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
   );

   modport slave (
      input  ireq_valid, ireq_addr, instr_valid, raw_instr, pc,
      output iresp_data_ok, iresp_data, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one bus request at a time and holds the returned word.
// Latency: instr_valid rises one cycle after iresp_data_ok; all outputs come straight from registers.
// Backpressure: HOLD persists while stall=1; redirect_valid squashes the held or in-flight instruction.
// Ports:
//   clk     core clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     ifetch_ctrl_if.master (instruction bus request/response, fetch-stage hand-off, stall/redirect)
module ifetch_ctrl #(
   parameter logic [63:0] PCINIT = 64'h8000_0000
) (
   input  logic          clk,
   input  logic          resetn,
   ifetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2,   // request in flight whose response must be thrown away
      S_HOLD = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] fpc_q, fpc_d;
   logic [63:0] hold_pc_q, hold_pc_d;
   logic [63:0] pend_pc_q, pend_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (bus.redirect_valid) begin
               // A redirect landing with the response re-requests straight away
               if (!bus.iresp_data_ok) state_d = S_DROP;
            end else if (bus.iresp_data_ok) begin
               state_d = S_HOLD;
            end
         end
         S_DROP: begin
            if (bus.iresp_data_ok) state_d = S_REQ;
         end
         S_HOLD: begin
            if (bus.redirect_valid || !bus.stall) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; the request address only moves when nothing is outstanding
   always_comb begin
      fpc_d        = fpc_q;
      hold_pc_d    = hold_pc_q;
      pend_pc_d    = pend_pc_q;
      hold_instr_d = hold_instr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.redirect_valid) fpc_d = bus.redirect_pc;
         end
         S_REQ: begin
            if (bus.redirect_valid) begin
               pend_pc_d = bus.redirect_pc;
               if (bus.iresp_data_ok) fpc_d = bus.redirect_pc;
            end else if (bus.iresp_data_ok) begin
               hold_instr_d = bus.iresp_data;
               hold_pc_d    = fpc_q;
            end
         end
         S_DROP: begin
            if (bus.redirect_valid) pend_pc_d = bus.redirect_pc;
            if (bus.iresp_data_ok) begin
               // The latest redirect wins, including one arriving with the response
               fpc_d = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
            end
         end
         S_HOLD: begin
            if (bus.redirect_valid) begin
               fpc_d = bus.redirect_pc;
            end else if (!bus.stall) begin
               fpc_d = hold_pc_q + 64'd4;   // wraps modulo 2^64
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fpc_q        <= PCINIT;
         hold_pc_q    <= '0;
         pend_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         fpc_q        <= fpc_d;
         hold_pc_q    <= hold_pc_d;
         pend_pc_q    <= pend_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Outputs: decoded from registered state only
   always_comb begin
      bus.ireq_valid  = (state_q == S_REQ) || (state_q == S_DROP);
      bus.ireq_addr   = fpc_q;
      bus.instr_valid = (state_q == S_HOLD);
      bus.raw_instr   = hold_instr_q;
      bus.pc          = hold_pc_q;
   end

endmodule
